// File: rtl/wb_stage_pkg.sv
// Shared constants for the writeback stage: datapath width, load funct3 encodings
// and the hard-wired zero register.
package wb_stage_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Load funct3 encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // True when rd names a real architectural register (not x0)
    function automatic logic is_wr_target(input logic [4:0] rd);
        return rd != REG_X0;
    endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data formatter: picks the addressed byte/halfword out of the raw memory word,
// sign- or zero-extends it, and flags misaligned accesses and illegal funct3 codes.
// Purely combinational.
module wb_stage_load_align #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o,
    output logic            fault_o
);
    import wb_stage_pkg::*;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then extend according to the load type
    always_comb begin
        byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
        data_o   = '0;
        fault_o  = 1'b0;
        case (funct3_i)
            LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            LH: begin
                data_o  = {{(XLEN-16){half_sel[15]}}, half_sel};
                fault_o = addr_lo_i[0];
            end
            LHU: begin
                data_o  = {{(XLEN-16){1'b0}}, half_sel};
                fault_o = addr_lo_i[0];
            end
            LW: begin
                data_o  = rdata_i;
                fault_o = addr_lo_i != 2'b00;
            end
            default: fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates between load data (fixed priority) and EX results,
// formats loads, and registers one register-file write per cycle. x0 writes are
// squashed at wen so the regfile bypass never forwards a value for x0.
// Optional feature: define WB_RETIRE_CNT_EN to add the 64-bit instret counter port.
module wb_stage #(
    parameter int unsigned XLEN   = wb_stage_pkg::XLEN,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  logic [4:0]        ex_rd_i,
    input  logic              ex_rd_wen_i,
    input  logic [XLEN-1:0]   ex_result_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [4:0]        mem_rd_i,
    input  logic [2:0]        mem_funct3_i,
    input  logic [1:0]        mem_addr_lo_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              wen_o,
    output logic [ADDR_W-1:0] wraddr_o,
    output logic [XLEN-1:0]   wrdata_o,
    output logic              err_load_o,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]       instret_o,
`endif
    input  logic              err_clr_i
);
    import wb_stage_pkg::*;

    logic              mem_fire;
    logic              ex_fire;
    logic [XLEN-1:0]   ld_data;
    logic              ld_fault;

    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [XLEN-1:0]   wrdata_q, wrdata_d;
    logic              err_q, err_d;

    wb_stage_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .funct3_i (mem_funct3_i),
        .addr_lo_i(mem_addr_lo_i),
        .rdata_i  (mem_rdata_i),
        .data_o   (ld_data),
        .fault_o  (ld_fault)
    );

    // Handshake: loads are always accepted and block EX for that cycle
    always_comb begin
        mem_ready_o = 1'b1;
        ex_ready_o  = ~mem_valid_i;
        mem_fire    = mem_valid_i;
        ex_fire     = ex_valid_i & ~mem_valid_i;
    end

    // Next-state for the write port and the sticky error flag
    always_comb begin
        wen_d    = 1'b0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        err_d    = err_q;
        if (err_clr_i) begin
            err_d = 1'b0;
        end
        if (mem_fire) begin
            wen_d    = is_wr_target(mem_rd_i) && !ld_fault;
            wraddr_d = ADDR_W'(mem_rd_i);
            wrdata_d = ld_data;
            // Set overrides a simultaneous clear
            if (ld_fault) begin
                err_d = 1'b1;
            end
        end else if (ex_fire) begin
            wen_d    = ex_rd_wen_i && is_wr_target(ex_rd_i);
            wraddr_d = ADDR_W'(ex_rd_i);
            wrdata_d = ex_result_i;
        end
    end

    // Output register and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q    <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wen_q    <= wen_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            err_q    <= err_d;
        end
    end

    assign wen_o      = wen_q;
    assign wraddr_o   = wraddr_q;
    assign wrdata_o   = wrdata_q;
    assign err_load_o = err_q;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret_q, instret_d;

    // Counts every accepted transfer, including x0 targets and faulting loads
    always_comb begin
        instret_d = instret_q;
        if (mem_fire || ex_fire) begin
            instret_d = instret_q + 64'd1;
        end
    end

    // Retire counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret_o = instret_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage. Expected writes are queued when stimulus is
// driven and popped one cycle later when the registered write port is sampled.
module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic [31:0] ex_result;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [1:0]  mem_addr_lo;
    logic [31:0] mem_rdata;
    logic        wen;
    logic [31:0] wraddr;
    logic [31:0] wrdata;
    logic        err_load;
    logic        err_clr;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] instret;
`endif

    typedef struct packed {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    wb_stage u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid),
        .ex_ready_o   (ex_ready),
        .ex_rd_i      (ex_rd),
        .ex_rd_wen_i  (ex_rd_wen),
        .ex_result_i  (ex_result),
        .mem_valid_i  (mem_valid),
        .mem_ready_o  (mem_ready),
        .mem_rd_i     (mem_rd),
        .mem_funct3_i (mem_funct3),
        .mem_addr_lo_i(mem_addr_lo),
        .mem_rdata_i  (mem_rdata),
        .wen_o        (wen),
        .wraddr_o     (wraddr),
        .wrdata_o     (wrdata),
        .err_load_o   (err_load),
`ifdef WB_RETIRE_CNT_EN
        .instret_o    (instret),
`endif
        .err_clr_i    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ex_valid  = 1'b0;
        mem_valid = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic drive_ex(input logic [4:0] rd, input logic rd_wen, input logic [31:0] res);
        ex_valid  = 1'b1;
        ex_rd     = rd;
        ex_rd_wen = rd_wen;
        ex_result = res;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                              input logic [31:0] w);
        mem_valid   = 1'b1;
        mem_rd      = rd;
        mem_funct3  = f3;
        mem_addr_lo = lo;
        mem_rdata   = w;
    endtask

    // Reference load formatter, shift based
    function automatic void model_load(input logic [2:0] f3, input logic [1:0] lo,
                                       input logic [31:0] w, output logic [31:0] d,
                                       output logic flt);
        logic [31:0] s;
        s   = w >> (32'(lo) * 8);
        d   = 32'h0;
        flt = 1'b0;
        case (f3)
            3'b000: d = {{24{s[7]}}, s[7:0]};
            3'b100: d = {24'h0, s[7:0]};
            3'b001: begin d = {{16{s[15]}}, s[15:0]}; flt = lo[0]; end
            3'b101: begin d = {16'h0, s[15:0]}; flt = lo[0]; end
            3'b010: begin d = w; flt = (lo != 2'd0); end
            default: flt = 1'b1;
        endcase
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        ex_rd = 0; ex_rd_wen = 0; ex_result = 0;
        mem_rd = 0; mem_funct3 = 0; mem_addr_lo = 0; mem_rdata = 0;
        #2;
        tests_run++;
        if (wen !== 1'b0 || wraddr !== 32'h0 || wrdata !== 32'h0 || err_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: wen=%b wraddr=%h wrdata=%h err=%b, want all 0",
                     wen, wraddr, wrdata, err_load);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (instret !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_instret: got %0d want 0", instret);
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        tests_run++;
        if (ex_ready !== 1'b1 || mem_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: ex_ready=%b mem_ready=%b want 1/1", ex_ready, mem_ready);
        end
        tests_run++;
        if (wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_wen: got %b want 0", wen);
        end
    endtask

    task automatic test_ex_write();
        exp_t e;
        drive_ex(5'd5, 1'b1, 32'hDEADBEEF);
        sb.push_back('{wen: 1'b1, addr: 5'd5, data: 32'hDEADBEEF});
        tick();
        drive_idle();
        sb.push_back('{wen: 1'b0, addr: 5'd0, data: 32'h0});
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            tests_run++;
            if (wen !== e.wen || (e.wen && (wraddr !== {27'h0, e.addr} || wrdata !== e.data)))
            begin
                tests_failed++;
                $display("FAIL ex_write[%0d]: got wen=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                         i, wen, wraddr, wrdata, e.wen, e.addr, e.data);
            end
            if (i == 0) tick();
        end
        tick();
    endtask

    task automatic test_x0();
        exp_t e;
`ifdef WB_RETIRE_CNT_EN
        logic [63:0] cnt0;
        cnt0 = instret;
`endif
        drive_ex(5'd0, 1'b1, 32'h12345678);
        #1;
        tests_run++;
        if (ex_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL x0_ready: got %b want 1", ex_ready);
        end
        sb.push_back('{wen: 1'b0, addr: 5'd0, data: 32'h12345678});
        tick();
        drive_idle();
        e = sb.pop_front();
        tests_run++;
        if (wen !== e.wen) begin
            tests_failed++;
            $display("FAIL x0_wen: got %b want %b", wen, e.wen);
        end
`ifdef WB_RETIRE_CNT_EN
        tests_run++;
        if (instret !== cnt0 + 64'd1) begin
            tests_failed++;
            $display("FAIL x0_instret: got %0d want %0d", instret, cnt0 + 64'd1);
        end
`endif
        // EX instruction without rd write
        drive_ex(5'd9, 1'b0, 32'hCAFEF00D);
        sb.push_back('{wen: 1'b0, addr: 5'd9, data: 32'hCAFEF00D});
        tick();
        drive_idle();
        e = sb.pop_front();
        tests_run++;
        if (wen !== e.wen) begin
            tests_failed++;
            $display("FAIL no_rd_wen: got %b want %b", wen, e.wen);
        end
    endtask

    task automatic test_load_format();
        exp_t        e;
        logic [2:0]  f3s[5];
        logic [1:0]  los[5];
        logic [31:0] exps[5];
        logic [31:0] w, d;
        logic [4:0]  rd;
        logic        flt;
        f3s  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        los  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        exps = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h80FF7F01};
        // Back-to-back loads from the fixed table
        for (int i = 0; i < 5; i++) begin
            drive_load(5'd3, f3s[i], los[i], 32'h80FF7F01);
            sb.push_back('{wen: 1'b1, addr: 5'd3, data: exps[i]});
            tick();
            e = sb.pop_front();
            tests_run++;
            if (wen !== e.wen || wraddr !== {27'h0, e.addr} || wrdata !== e.data) begin
                tests_failed++;
                $display("FAIL load_fmt[%0d]: got wen=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                         i, wen, wraddr, wrdata, e.wen, e.addr, e.data);
            end
        end
        // Sweep every funct3/offset against the reference model
        for (int f = 0; f < 8; f++) begin
            for (int l = 0; l < 4; l++) begin
                w  = $urandom;
                rd = 5'($urandom_range(0, 31));
                model_load(3'(f), 2'(l), w, d, flt);
                drive_load(rd, 3'(f), 2'(l), w);
                sb.push_back('{wen: (rd != 5'd0) && !flt, addr: rd, data: d});
                tick();
                e = sb.pop_front();
                tests_run++;
                if (wen !== e.wen || (e.wen && (wraddr !== {27'h0, e.addr} || wrdata !== e.data)))
                begin
                    tests_failed++;
                    $display("FAIL load_sweep f3=%0d lo=%0d: got wen=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                             f, l, wen, wraddr, wrdata, e.wen, e.addr, e.data);
                end
            end
        end
        drive_idle();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (err_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_err_clr: got %b want 0", err_load);
        end
    endtask

    task automatic test_priority();
        exp_t e;
        drive_ex(5'd8, 1'b1, 32'h0000_0888);
        drive_load(5'd7, 3'b010, 2'd0, 32'h0000_0777);
        #1;
        tests_run++;
        if (ex_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_ex_ready: got %b want 0", ex_ready);
        end
        sb.push_back('{wen: 1'b1, addr: 5'd7, data: 32'h0000_0777});
        tick();
        mem_valid = 1'b0;
        #1;
        tests_run++;
        if (ex_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_ex_ready_after: got %b want 1", ex_ready);
        end
        sb.push_back('{wen: 1'b1, addr: 5'd8, data: 32'h0000_0888});
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            tests_run++;
            if (wen !== e.wen || wraddr !== {27'h0, e.addr} || wrdata !== e.data) begin
                tests_failed++;
                $display("FAIL prio_write[%0d]: got wen=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                         i, wen, wraddr, wrdata, e.wen, e.addr, e.data);
            end
            if (i == 0) begin
                tick();
                drive_idle();
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            drive_ex(5'(10 + i), 1'b1, 32'hA000_0000 + 32'(i));
            sb.push_back('{wen: 1'b1, addr: 5'(10 + i), data: 32'hA000_0000 + 32'(i)});
            tick();
            e = sb.pop_front();
            tests_run++;
            if (wen !== e.wen || wraddr !== {27'h0, e.addr} || wrdata !== e.data) begin
                tests_failed++;
                $display("FAIL b2b[%0d]: got wen=%b addr=%h data=%h want wen=%b addr=%h data=%h",
                         i, wen, wraddr, wrdata, e.wen, e.addr, e.data);
            end
        end
        drive_idle();
        tick();
        tests_run++;
        if (wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_drain: got wen=%b want 0", wen);
        end
    endtask

    task automatic test_fault();
        exp_t e;
        drive_load(5'd4, 3'b010, 2'd2, 32'h1111_2222);
        sb.push_back('{wen: 1'b0, addr: 5'd4, data: 32'h0});
        tick();
        drive_idle();
        e = sb.pop_front();
        tests_run++;
        if (wen !== e.wen || err_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_set: got wen=%b err=%b want wen=%b err=1", wen, err_load, e.wen);
        end
        tick();
        tick();
        tests_run++;
        if (err_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL fault_sticky: got %b want 1", err_load);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests_run++;
        if (err_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_clr: got %b want 0", err_load);
        end
        // Fault and clear on the same edge: set wins
        drive_load(5'd4, 3'b110, 2'd0, 32'h0);
        err_clr = 1'b1;
        tick();
        drive_idle();
        tests_run++;
        if (err_load !== 1'b1 || wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_vs_clr: got err=%b wen=%b want err=1 wen=0", err_load, wen);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        // Leave the error flag set, then put a write on the port
        drive_load(5'd2, 3'b001, 2'd1, 32'h0);
        tick();
        drive_idle();
        drive_ex(5'd9, 1'b1, 32'h5A5A_5A5A);
        tick();
        drive_idle();
        tests_run++;
        if (wen !== 1'b1 || err_load !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_pre: got wen=%b err=%b want 1/1", wen, err_load);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (wen !== 1'b0 || wraddr !== 32'h0 || wrdata !== 32'h0 || err_load !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got wen=%b addr=%h data=%h err=%b want all 0",
                     wen, wraddr, wrdata, err_load);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (wen !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_after: got wen=%b want 0", wen);
        end
    endtask

    initial begin
        test_reset();
        test_ex_write();
        test_x0();
        test_load_format();
        test_priority();
        test_back_to_back();
        test_fault();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the RV32 core; sits directly upstream of the register file and drives its write port (wen / wraddr / wrdata).
- Accepts results from two producers:
  - ALU results from EX.
  - Raw load data from the data-memory interface.
- Arbitrates between them, aligns and sign-extends load data, and registers one write per cycle.
- Suppresses x0 writes so the register file's write-to-read bypass never forwards a non-zero value for x0.

Parameters:
- XLEN, 32, datapath width.
- ADDR_W, 32, width of the wraddr output; matches the register-file port width, only bits [4:0] significant.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX result valid.
- ex_ready  out  1  WB accepts the EX result this cycle.
- ex_rd  in  5  EX destination register.
- ex_rd_wen  in  1  EX instruction writes rd (0 for stores/branches).
- ex_result  in  XLEN  ALU/jump-link result.
- mem_valid  in  1  load data valid.
- mem_ready  out  1  WB accepts the load data; tied to 1.
- mem_rd  in  5  load destination register.
- mem_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_addr_lo  in  2  load address bits [1:0].
- mem_rdata  in  XLEN  raw aligned word from data memory.
- wen  out  1  register-file write enable.
- wraddr  out  ADDR_W  register-file write address, zero-extended rd.
- wrdata  out  XLEN  register-file write data.
- err_load  out  1  sticky load fault flag (misaligned or illegal funct3).
- err_clr  in  1  clears err_load.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - wen=0, wraddr=0, wrdata=0, err_load=0.
  - Takes effect immediately, mid-transfer included; any in-flight write is discarded.
- Handshake:
  - A transfer occurs on a rising edge with valid&ready.
  - mem_ready=1 always.
  - ex_ready = !mem_valid, so a load has fixed priority over EX.
  - EX must hold ex_valid and its payload stable while ex_ready=0.
- Latency:
  - Input accepted at edge N → wen/wraddr/wrdata valid during cycle N+1.
  - Outputs are held for exactly one cycle.
  - wen=0 in any cycle following an edge with no accepted write.
- Write qualification:
  - EX path: wen_next = ex_rd_wen && ex_rd!=0.
  - Load path: wen_next = mem_rd!=0 && !fault.
  - rd==0 → wen=0, but the transfer still completes.
- Load formatting (byte select = mem_addr_lo):
  - LB/LBU: byte [8*lo+7:8*lo], sign- or zero-extended to XLEN.
  - LH/LHU: halfword [16*lo[1]+15:16*lo[1]], sign- or zero-extended.
  - LW: full word.
- Faults:
  - Misaligned load: LH/LHU with lo[0]=1, or LW with lo!=0.
  - Illegal funct3: 011, 110, 111.
  - On a fault: no write, err_load set to 1 at the accept edge.
- err_load:
  - Sticky; cleared by err_clr=1 at an edge.
  - If a fault and err_clr=1 occur on the same edge, set wins.
- Simultaneous events:
  - mem_valid & ex_valid in the same cycle → only the load is taken; EX waits.
  - Back-to-back loads starve EX indefinitely; upstream guarantees this is bounded.
- No internal storage beyond the output register and the error flag; there is no full/empty state to manage.

Optional Feature:
- Macro WB_RETIRE_CNT_EN.
- Defined:
  - Adds output port instret (64 bits).
  - Reset to 0.
  - Increments by 1 on every accepted transfer (EX or load), including rd==0 and faulting loads.
  - Wraps from 2^64-1 to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines file holds:
  - Load funct3 constants: LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101.
  - XLEN.
  - REG_X0=5'd0.
- One natural sub-module: load_align. It is purely combinational:
  - Inputs: funct3, addr_lo, rdata.
  - Outputs: formatted data and fault.
- The wb_stage top contains the arbiter, the output register and the error flag.

Test Plan:
- EX write:
  - Stimulus: ex_valid=1, ex_rd=5, ex_rd_wen=1, ex_result=0xDEADBEEF.
  - Response: next cycle wen=1, wraddr=5, wrdata=0xDEADBEEF; following cycle wen=0.
- x0 suppression:
  - Stimulus: EX write to rd=0 with result 0x12345678.
  - Response: ex_ready=1, wen stays 0; with WB_RETIRE_CNT_EN, instret increments by 1.
- Load formatting:
  - Stimulus: mem_rdata=0x80FF7F01, rd=3.
  - Response:
    - LB lo=3 → wrdata=0xFFFFFF80.
    - LBU lo=1 → 0x0000007F.
    - LH lo=2 → 0xFFFF80FF.
    - LHU lo=0 → 0x00007F01.
    - LW lo=0 → 0x80FF7F01.
- Priority:
  - Stimulus: mem_valid and ex_valid together (mem_rd=7, ex_rd=8).
  - Response: ex_ready=0; write to 7 first; EX write to 8 on the next cycle after mem_valid drops.
- Fault:
  - Stimulus: LW with lo=2, rd=4.
  - Response: wen=0, err_load=1 and remains set; err_clr pulse clears it.
  - Stimulus: fault and err_clr on the same edge.
  - Response: err_load=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while wen=1.
  - Response: wen, wraddr, wrdata and err_load go to 0 immediately, without waiting for a clock edge.
